// File: rtl/parity_sched.sv
// rtl/parity_sched.sv - round-robin scheduler feeding one serial parity engine
// Grants one requester at a time, streams its word LSB-first into the engine, returns tagged parity.
module parity_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_parity,
  output logic [IDW-1:0]        res_id,
  output logic                  par_reset,
  output logic                  par_in,
  input  logic                  par_out,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_SHIFT, S_SAMPLE, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_rr_ptr;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_word;
  logic [IDW-1:0]   r_id;
  logic             r_res_valid;
  logic             r_res_parity;
  logic [IDW-1:0]   r_res_id;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [WIDTH-1:0] w_word;
  int               w_best;
  int               w_dist;

  // Winner is the valid requester with the smallest circular distance from rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_word   = '0;
    w_best   = NREQ;
    w_dist   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i >= int'(r_rr_ptr)) ? (i - int'(r_rr_ptr)) : (i + NREQ - int'(r_rr_ptr));
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_found  = 1'b1;
        w_winner = IDW'(i);
        w_word   = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_CLR;
      S_CLR:    w_next = S_SHIFT;
      S_SHIFT:  if (r_bit_cnt == CW'(WIDTH - 1)) w_next = S_SAMPLE;
      S_SAMPLE: w_next = S_DONE;
      S_DONE:   if (res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_bit_cnt    <= '0;
      r_word       <= '0;
      r_id         <= '0;
      r_res_valid  <= 1'b0;
      r_res_parity <= 1'b0;
      r_res_id     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_word   <= w_word;
            r_id     <= w_winner;
            r_rr_ptr <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);
          end
        end
        S_CLR: r_bit_cnt <= '0;
        // The word register shifts right so bit 0 always holds word[bit_cnt].
        S_SHIFT: begin
          r_word    <= r_word >> 1;
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
        S_SAMPLE: begin
          r_res_parity <= par_out;
          r_res_id     <= r_id;
          r_res_valid  <= 1'b1;
        end
        S_DONE: if (res_ready) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE && !reset && w_found) ? (NREQ'(1) << w_winner) : '0;
  assign par_reset  = reset || (r_state == S_CLR);
  assign par_in     = (r_state == S_SHIFT) ? r_word[0] : 1'b0;
  assign res_valid  = r_res_valid;
  assign res_parity = r_res_parity;
  assign res_id     = r_res_id;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_parity_sched.sv
// tb/tb_parity_sched.sv - scoreboard bench for parity_sched with a reference parity engine
// Monitor on negedge checks grants, serial stream and results against a behavioural model.
module tb_parity_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic                  res_valid;
  logic                  res_ready = 1'b1;
  logic                  res_parity;
  logic [IDW-1:0]        res_id;
  logic                  par_reset;
  logic                  par_in;
  logic                  par_out;
  logic                  busy;

  parity_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_parity(res_parity), .res_id(res_id), .par_reset(par_reset),
    .par_in(par_in), .par_out(par_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference serial parity engine
  logic eng = 1'b0;
  always @(posedge clk) begin
    if (par_reset) eng <= 1'b0;
    else           eng <= eng ^ par_in;
  end
  assign par_out = eng;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic           par;
    logic [IDW-1:0] id;
  } res_t;

  res_t       sb[$];
  int         grant_log[$];
  int         rr_m = 0;
  bit         inflight = 0;
  int         g_cyc = 0;
  logic [7:0] g_word = '0;
  bit         was_rst = 0;
  bit         prev_valid = 0;
  bit         prev_hs = 0;
  logic       prev_par = 0;
  logic [1:0] prev_id = 0;

  always @(negedge clk) begin
    int         off;
    int         win;
    logic       exp_pin;
    logic [3:0] exp_rdy;
    bit         exp_busy;
    res_t       e;
    if (reset) begin
      chk("rst_par_reset", 32'(par_reset), 1);
      chk("rst_req_ready", 32'(req_ready), 0);
      sb.delete();
      inflight   = 0;
      rr_m       = 0;
      prev_valid = 0;
      prev_hs    = 0;
      was_rst    = 1;
    end else begin
      if (was_rst) begin
        chk("post_rst_res_valid", 32'(res_valid), 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_res_parity", 32'(res_parity), 0);
        chk("post_rst_res_id", 32'(res_id), 0);
        was_rst = 0;
      end
      off      = cyc - g_cyc;
      exp_busy = inflight && (off != 0);
      chk("busy", 32'(busy), 32'(exp_busy));
      exp_pin = (inflight && off >= 2 && off <= WIDTH + 1) ? (((g_word >> (off - 2)) & 8'd1) != 0) : 1'b0;
      chk("par_in", 32'(par_in), 32'(exp_pin));
      if (inflight && off >= 1 && off <= WIDTH + 2)
        chk("par_reset", 32'(par_reset), (off == 1) ? 1 : 0);
      chk("res_valid", 32'(res_valid), (inflight && off >= WIDTH + 3) ? 1 : 0);
      if (prev_valid && !prev_hs) begin
        chk("hold_parity", 32'(res_parity), 32'(prev_par));
        chk("hold_id", 32'(res_id), 32'(prev_id));
      end
      exp_rdy = '0;
      win     = -1;
      if (!exp_busy) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (req_valid[(rr_m + k) % NREQ]) win = (rr_m + k) % NREQ;
        if (win >= 0) exp_rdy = 4'(1 << win);
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(res_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("res_parity", 32'(res_parity), 32'(e.par));
          chk("res_id", 32'(res_id), 32'(e.id));
        end
        inflight = 0;
      end
      if (win >= 0) begin
        g_word = req_data[win*WIDTH +: WIDTH];
        e.par  = ($countones(g_word) % 2) == 1;
        e.id   = 2'(win);
        sb.push_back(e);
        grant_log.push_back(win);
        inflight = 1;
        g_cyc    = cyc;
        rr_m     = (win + 1) % NREQ;
      end
      prev_valid = res_valid;
      prev_hs    = res_valid && res_ready;
      prev_par   = res_parity;
      prev_id    = res_id;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [7:0] w);
    bit ok = 0;
    req_data[id*WIDTH +: WIDTH] = w;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1; break; end
    end
    if (!ok) chk("grant_timeout", 0, 1);
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy && !res_valid && sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_grants(input int total);
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (grant_log.size() >= total) begin ok = 1; break; end
    end
    if (!ok) chk("grants_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int         base;
    logic [7:0] pv [5];
    pv = '{8'h00, 8'h01, 8'h03, 8'hFF, 8'h80};
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset in the middle of shifting 0xFF: no result may appear
    send(0, 8'hFF);
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("no_result_after_reset", 32'(sb.size()), 0);

    send(0, 8'hB5);
    wait_idle();
    foreach (pv[i]) begin
      send(2, pv[i]);
      wait_idle();
    end

    // Round robin from rr_ptr=0
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    grant_log.delete();
    req_data  = {$urandom, $urandom} & 32'hFFFF_FFFF;
    req_valid = 4'hF;
    wait_grants(5);
    req_valid = '0;
    wait_idle();
    chk("rr_g0", grant_log[0], 0);
    chk("rr_g1", grant_log[1], 1);
    chk("rr_g2", grant_log[2], 2);
    chk("rr_g3", grant_log[3], 3);
    chk("rr_g4", grant_log[4], 0);
    send(1, 8'h5A);
    wait_idle();
    req_valid = 4'b1010;
    wait_grants(8);
    req_valid = '0;
    wait_idle();
    chk("rr_g6", grant_log[6], 3);
    chk("rr_g7", grant_log[7], 1);

    // Backpressure
    res_ready = 1'b0;
    base      = grant_log.size();
    req_valid = 4'b0011;
    wait_grants(base + 1);
    for (int n = 0; n < 50 && !res_valid; n++) tick();
    repeat (20) tick();
    chk("bp_no_grant", grant_log.size(), base + 1);
    res_ready = 1'b1;
    wait_grants(base + 2);
    req_valid = '0;
    wait_idle();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = {$urandom};
      res_ready = ($urandom_range(0, 9) < 7);
    end_loop: begin end
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    wait_idle();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
